// File: rtl/eeprom_resp.sv
// eeprom_resp: two-wire serial EEPROM responder with a 2^ADDR_W byte memory.
// The control byte selects the device and the upper pointer bits. The address
// byte sets pointer[7:0], and data bytes are written or read at the pointer.
// Build macro EEPROM_SEQ_ACCESS_EN enables multi-byte writes and sequential
// reads. Without it, each transaction handles a single data byte.
// ADDR_W must be at least 8.
module eeprom_resp #(
    parameter int unsigned ADDR_W = 11,
    parameter logic [3:0]  DEV_ID = 4'b1010
) (
    input  logic CLK,
    input  logic RESET,
    input  logic SCL,
    inout  wire  SDA,
    output logic BUSY,
    output logic WR_PULSE
);
`ifdef EEPROM_SEQ_ACCESS_EN
    localparam bit SEQ_EN = 1'b1;
`else
    localparam bit SEQ_EN = 1'b0;
`endif
    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [3:0] {
        IDLE, CTRL, CTRL_ACK, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        scl_sync_q, scl_sync_d;
    logic [1:0]        sda_sync_q, sda_sync_d;
    logic              scl_prev_q, scl_prev_d;
    logic              sda_prev_q, sda_prev_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [1:0]        phase_q, phase_d;
    logic              sda_oe_q, sda_oe_d;
    logic              wr_pulse_q, wr_pulse_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [7:0]        shift_q, shift_d;
    logic              mem_we;
    logic [7:0]        mem [DEPTH];

    logic              scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
    logic [7:0]        rx_byte, rd_byte;
    logic [ADDR_W-1:0] ptr_inc, ptr_ctrl, ptr_addr;

    // Line conditions are taken from synchronized samples and their previous values
    assign scl_s     = scl_sync_q[1];
    assign sda_s     = sda_sync_q[1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

    assign rx_byte  = {shift_q[6:0], sda_s};
    assign rd_byte  = mem[ptr_q];
    assign ptr_inc  = ptr_q + ADDR_W'(1);
    assign ptr_ctrl = ADDR_W'({rx_byte[3:1], ptr_q[7:0]});
    assign ptr_addr = (ptr_q & ~ADDR_W'(8'hFF)) | ADDR_W'(rx_byte);

    assign SDA      = sda_oe_q ? 1'b0 : 1'bz;
    assign BUSY     = (state_q != IDLE);
    assign WR_PULSE = wr_pulse_q;

    // Synchronizer shift and previous-sample capture
    always_comb begin
        scl_sync_d = {scl_sync_q[0], SCL};
        sda_sync_d = {sda_sync_q[0], SDA};
        scl_prev_d = scl_sync_q[1];
        sda_prev_d = sda_sync_q[1];
    end

    // Protocol FSM: bit sampling on SCL rise, SDA updates on SCL fall, START/STOP override
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        phase_d    = phase_q;
        sda_oe_d   = sda_oe_q;
        ptr_d      = ptr_q;
        shift_d    = shift_q;
        wr_pulse_d = 1'b0;
        mem_we     = 1'b0;
        case (state_q)
            IDLE: ;
            CTRL: if (scl_rise) begin
                shift_d   = rx_byte;
                bit_cnt_d = bit_cnt_q + 3'd1;
                phase_d   = 2'd0;
                if (bit_cnt_q == 3'd7) begin
                    if (rx_byte[7:4] == DEV_ID) begin
                        state_d = CTRL_ACK;
                        ptr_d   = ptr_ctrl;
                    end else begin
                        state_d = WAIT_STOP;
                    end
                end
            end
            ADDR: if (scl_rise) begin
                shift_d   = rx_byte;
                bit_cnt_d = bit_cnt_q + 3'd1;
                phase_d   = 2'd0;
                if (bit_cnt_q == 3'd7) begin
                    state_d = ADDR_ACK;
                    ptr_d   = ptr_addr;
                end
            end
            WDATA: if (scl_rise) begin
                shift_d   = rx_byte;
                bit_cnt_d = bit_cnt_q + 3'd1;
                phase_d   = 2'd0;
                if (bit_cnt_q == 3'd7) begin
                    state_d    = WDATA_ACK;
                    mem_we     = 1'b1;
                    wr_pulse_d = 1'b1;
                    ptr_d      = ptr_inc;
                end
            end
            // The first fall pulls SDA low and the second fall ends the ACK clock
            CTRL_ACK, ADDR_ACK, WDATA_ACK: if (scl_fall) begin
                if (phase_q == 2'd0) begin
                    sda_oe_d = 1'b1;
                    phase_d  = 2'd1;
                end else begin
                    sda_oe_d  = 1'b0;
                    phase_d   = 2'd0;
                    bit_cnt_d = 3'd0;
                    if (state_q == CTRL_ACK) begin
                        if (shift_q[0]) begin
                            state_d  = RDATA;
                            shift_d  = rd_byte;
                            sda_oe_d = ~rd_byte[7];
                        end else begin
                            state_d = ADDR;
                        end
                    end else if (state_q == ADDR_ACK) begin
                        state_d = WDATA;
                    end else begin
                        state_d = SEQ_EN ? WDATA : WAIT_STOP;
                    end
                end
            end
            RDATA: begin
                if (scl_rise) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = RDATA_ACK;
                        ptr_d   = ptr_inc;
                        phase_d = 2'd0;
                    end
                end else if (scl_fall) begin
                    shift_d  = {shift_q[6:0], 1'b1};
                    sda_oe_d = ~shift_q[6];
                end
            end
            // Phase 0 releases SDA, phase 1 samples the master's ACK, phase 2 starts the next byte
            RDATA_ACK: begin
                if (scl_fall) begin
                    if (phase_q == 2'd0) begin
                        sda_oe_d = 1'b0;
                        phase_d  = 2'd1;
                    end else if (phase_q == 2'd2) begin
                        state_d   = RDATA;
                        bit_cnt_d = 3'd0;
                        phase_d   = 2'd0;
                        shift_d   = rd_byte;
                        sda_oe_d  = ~rd_byte[7];
                    end
                end else if (scl_rise && phase_q == 2'd1) begin
                    if (!sda_s && SEQ_EN) phase_d = 2'd2;
                    else                  state_d = WAIT_STOP;
                end
            end
            WAIT_STOP: sda_oe_d = 1'b0;
            default: state_d = IDLE;
        endcase
        if (start_det) begin
            state_d   = CTRL;
            bit_cnt_d = 3'd0;
            phase_d   = 2'd0;
            sda_oe_d  = 1'b0;
        end else if (stop_det) begin
            state_d   = IDLE;
            bit_cnt_d = 3'd0;
            phase_d   = 2'd0;
            sda_oe_d  = 1'b0;
        end
    end

    // Control state registers; asynchronous reset releases SDA immediately
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= IDLE;
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            bit_cnt_q  <= 3'd0;
            phase_q    <= 2'd0;
            sda_oe_q   <= 1'b0;
            wr_pulse_q <= 1'b0;
            ptr_q      <= '0;
        end else begin
            state_q    <= state_d;
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
            bit_cnt_q  <= bit_cnt_d;
            phase_q    <= phase_d;
            sda_oe_q   <= sda_oe_d;
            wr_pulse_q <= wr_pulse_d;
            ptr_q      <= ptr_d;
        end
    end

    // Data path: shift register and byte memory (neither is reset)
    always_ff @(posedge CLK) begin
        shift_q <= shift_d;
        if (mem_we) mem[ptr_q] <= rx_byte;
    end

endmodule

// File: tb/tb_eeprom_resp.sv
// Testbench for eeprom_resp: a bit-banged bus master and a transaction-level
// memory/pointer model queue expected ACKs and read bytes. Monitors compare
// these expectations against what the master samples and against WR_PULSE.
module tb_eeprom_resp;
    localparam logic [3:0] DEV = 4'b1010;
    localparam time        T   = 50ns;
`ifdef EEPROM_SEQ_ACCESS_EN
    localparam bit SEQ = 1'b1;
`else
    localparam bit SEQ = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic scl;
    logic m_oe;
    wire  sda;
    logic busy, wr_pulse;

    pullup (sda);
    assign sda = m_oe ? 1'b0 : 1'bz;

    eeprom_resp #(.ADDR_W(11), .DEV_ID(DEV)) dut (
        .CLK(clk), .RESET(rst_n), .SCL(scl), .SDA(sda), .BUSY(busy), .WR_PULSE(wr_pulse)
    );

    always #5ns clk = ~clk;

    typedef struct { string name; logic [7:0] val; bit chk; } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  obs_q[$];
    logic [10:0] wr_exp_q[$];
    logic [7:0]  wbuf[$];
    logic [10:0] addr_log[$];
    logic [7:0]  mem_m [2048];
    bit          written_m [2048];
    logic [10:0] ptr_m;
    int          n_chk = 0;
    int          n_fail = 0;
    logic        wr_prev = 1'b0;
    exp_t        e_mon;
    logic [7:0]  o_mon;

    task automatic check(string name, logic [7:0] act, logic [7:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic expect_item(string name, logic [7:0] val, bit chk);
        exp_t e;
        e.name = name; e.val = val; e.chk = chk;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: compares every sampled response with the next expectation
    always @(negedge clk) begin
        if (obs_q.size() > 0) begin
            o_mon = obs_q.pop_front();
            if (exp_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected response: got %h, expected none", o_mon);
            end else begin
                e_mon = exp_q.pop_front();
                if (e_mon.chk) check(e_mon.name, o_mon, e_mon.val);
            end
        end
    end

    // Write-pulse monitor: one-CLK pulses, each matching a queued commit
    always @(negedge clk) begin
        if (wr_pulse) begin
            if (wr_prev) begin
                n_chk++; n_fail++;
                $display("FAIL WR_PULSE width: got >1 cycle, expected 1");
            end else if (wr_exp_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected WR_PULSE: got pulse, expected none");
            end else begin
                void'(wr_exp_q.pop_front());
                n_chk++;
            end
        end
        wr_prev <= wr_pulse;
    end

    task automatic bus_start();
        m_oe = 1'b0; #T; scl = 1'b1; #T; m_oe = 1'b1; #T; scl = 1'b0; #T;
        check("BUSY after START", {7'd0, busy}, 8'd1);
    endtask

    task automatic bus_stop();
        m_oe = 1'b1; #T; scl = 1'b1; #T; m_oe = 1'b0; #(2*T);
    endtask

    task automatic send_bit(bit b);
        m_oe = !b; #T; scl = 1'b1; #(2*T); scl = 1'b0; #T;
    endtask

    task automatic get_bit(output bit b);
        m_oe = 1'b0; #T; scl = 1'b1; #T; b = sda; #T; scl = 1'b0; #T;
    endtask

    task automatic write_byte(logic [7:0] b);
        bit a;
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        get_bit(a);
        obs_q.push_back({7'd0, a});
    endtask

    task automatic read_byte(bit master_ack);
        logic [7:0] v;
        bit bb;
        for (int i = 7; i >= 0; i--) begin
            get_bit(bb);
            v[i] = bb;
        end
        obs_q.push_back(v);
        send_bit(!master_ack);
        m_oe = 1'b0;
    endtask

    task automatic after_stop();
        #T;
        check("BUSY after STOP", {7'd0, busy}, 8'd0);
        check("pending write pulses", 8'(wr_exp_q.size()), 8'd0);
    endtask

    // Write transaction: ctrl, address, then the bytes in wbuf
    task automatic txn_write(logic [7:0] ctrl, logic [7:0] addr);
        bit sel;
        logic [10:0] p;
        sel = (ctrl[7:4] == DEV) && !ctrl[0];
        p = {ctrl[3:1], addr};
        expect_item("ctrl ack", {7'd0, !sel}, 1'b1);
        expect_item("addr ack", {7'd0, !sel}, 1'b1);
        foreach (wbuf[i]) begin
            if (sel && (i == 0 || SEQ)) begin
                expect_item("data ack", 8'd0, 1'b1);
                mem_m[p] = wbuf[i];
                written_m[p] = 1'b1;
                wr_exp_q.push_back(p);
                p = p + 11'd1;
            end else begin
                expect_item("data nack", 8'd1, 1'b1);
            end
        end
        if (sel) ptr_m = p;
        bus_start();
        write_byte(ctrl);
        write_byte(addr);
        foreach (wbuf[i]) write_byte(wbuf[i]);
        bus_stop();
        after_stop();
    endtask

    // Read transaction, optionally preceded by an address-setting write and a repeated START
    task automatic txn_read(bit set_addr, logic [7:0] ctrl_r, logic [7:0] addr, int n);
        if (set_addr) begin
            expect_item("ctrl(w) ack", 8'd0, 1'b1);
            expect_item("addr ack", 8'd0, 1'b1);
            ptr_m = {ctrl_r[3:1], addr};
        end
        expect_item("ctrl(r) ack", 8'd0, 1'b1);
        ptr_m[10:8] = ctrl_r[3:1];
        for (int i = 0; i < n; i++) begin
            if (i == 0 || SEQ) begin
                expect_item("read data", mem_m[ptr_m], written_m[ptr_m]);
                ptr_m = ptr_m + 11'd1;
            end else begin
                expect_item("read after single", 8'hFF, 1'b1);
            end
        end
        bus_start();
        if (set_addr) begin
            write_byte(ctrl_r & 8'hFE);
            write_byte(addr);
            bus_start();
        end
        write_byte(ctrl_r);
        for (int i = 0; i < n; i++) read_byte(i != n - 1);
        bus_stop();
        after_stop();
    endtask

    // Write data byte abandoned after a few bits by a STOP
    task automatic txn_partial(logic [7:0] ctrl, logic [7:0] addr, int nbits);
        expect_item("ctrl ack", 8'd0, 1'b1);
        expect_item("addr ack", 8'd0, 1'b1);
        ptr_m = {ctrl[3:1], addr};
        bus_start();
        write_byte(ctrl);
        write_byte(addr);
        for (int k = 0; k < nbits; k++) send_bit(1'($urandom_range(0, 1)));
        bus_stop();
        after_stop();
    endtask

    // Reset asserted while the responder drives a 0 data bit (5th bit of 8'hA5)
    task automatic txn_reset_mid_read();
        bit bb;
        expect_item("ctrl(w) ack", 8'd0, 1'b1);
        expect_item("addr ack", 8'd0, 1'b1);
        expect_item("ctrl(r) ack", 8'd0, 1'b1);
        bus_start();
        write_byte(8'hA4);
        write_byte(8'hC0);
        bus_start();
        write_byte(8'hA5);
        for (int i = 0; i < 4; i++) get_bit(bb);
        m_oe = 1'b0;
        #T;
        check("read bit5 driven low", {7'd0, sda}, 8'd0);
        rst_n = 1'b0;
        #1ns;
        check("SDA after async reset", {7'd0, sda}, 8'd1);
        check("BUSY after async reset", {7'd0, busy}, 8'd0);
        ptr_m = 11'd0;
        #(20ns);
        scl = 1'b1;
        #T;
        rst_n = 1'b1;
        #(2*T);
    endtask

    initial begin
        logic [7:0]  ctrl, addr;
        logic [10:0] a;
        int          n, kind;
        rst_n = 1'b0; scl = 1'b1; m_oe = 1'b0; ptr_m = 11'd0;
        #(100ns);
        check("reset BUSY", {7'd0, busy}, 8'd0);
        check("reset WR_PULSE", {7'd0, wr_pulse}, 8'd0);
        check("reset SDA", {7'd0, sda}, 8'd1);
        rst_n = 1'b1;
        #(100ns);

        wbuf = '{8'h77};            txn_write(8'hA2, 8'h35);
        wbuf = '{8'h5A};            txn_write(8'hA2, 8'h34);
        txn_read(1'b1, 8'hA3, 8'h34, 1);
        txn_read(1'b0, 8'hA3, 8'h00, 1);

        wbuf = '{8'h3C};            txn_write(8'hA0, 8'h00);
        wbuf = '{8'h11, 8'h22};     txn_write(8'hAE, 8'hFF);
        txn_read(1'b1, 8'hAF, 8'hFF, 1);
        txn_read(1'b1, 8'hA1, 8'h00, 1);

        wbuf = '{8'h99};            txn_write(8'hB0, 8'h12);
        txn_read(1'b1, 8'hA3, 8'h12, 1);

        wbuf = '{8'h4B};            txn_write(8'hA6, 8'h20);
        txn_partial(8'hA6, 8'h20, 4);
        txn_read(1'b1, 8'hA7, 8'h20, 1);

        wbuf = '{8'hA5};            txn_write(8'hA4, 8'hC0);
        txn_reset_mid_read();
        wbuf = '{8'hC3};            txn_write(8'hA2, 8'h56);
        txn_read(1'b1, 8'hA3, 8'h56, 1);

        for (int it = 0; it < 16; it++) begin
            kind = $urandom_range(0, 3);
            if (kind <= 1) begin
                a = 11'($urandom);
                n = $urandom_range(1, 3);
                wbuf.delete();
                for (int k = 0; k < n; k++) wbuf.push_back(8'($urandom));
                ctrl = {DEV, a[10:8], 1'b0};
                if ($urandom_range(0, 7) == 0) ctrl[7:4] = 4'b0110;
                else addr_log.push_back(a);
                txn_write(ctrl, a[7:0]);
            end else if (kind == 2 && addr_log.size() > 0) begin
                a = addr_log[$urandom_range(0, addr_log.size() - 1)];
                txn_read(1'b1, {DEV, a[10:8], 1'b1}, a[7:0], $urandom_range(1, 3));
            end else begin
                addr = 8'h00;
                txn_read(1'b0, {DEV, ptr_m[10:8], 1'b1}, addr, $urandom_range(1, 2));
            end
        end

        #(100ns);
        check("unconsumed expectations", 8'(exp_q.size()), 8'd0);
        check("unmatched responses", 8'(obs_q.size()), 8'd0);
        check("unseen write pulses", 8'(wr_exp_q.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/eeprom_resp.md
EEPROM_RESP -- requirements
Module: eeprom_resp

Interface
REQ-001 Parameter ADDR_W, default 11, memory address width; memory depth is 2^ADDR_W bytes.
REQ-002 Parameter DEV_ID, default 4'b1010, device-type code compared against control byte bits [7:4].
REQ-003 CLK  input  1  system clock; all state advances on its rising edge; CLK frequency SHALL be at least 8x SCL frequency.
REQ-004 RESET  input  1  asynchronous, active-low reset.
REQ-005 SCL  input  1  serial clock from the EEPROM master.
REQ-006 SDA  inout  1  serial data line; open-drain, driven only to 0, otherwise high-Z.
REQ-007 BUSY  output  1  high from START detect to STOP detect.
REQ-008 WR_PULSE  output  1  one-CLK pulse per data byte committed to memory.

Function
REQ-009 SCL and SDA SHALL each pass through a 2-flop synchronizer; edge/condition detection uses synchronized values (2-3 CLK latency).
REQ-010 START = SDA falling while SCL high; STOP = SDA rising while SCL high; both recognized in any state, including mid-byte.
REQ-011 SDA sampled on synchronized SCL rising edge, MSB first; SDA changed only on synchronized SCL falling edge.
REQ-012 States: IDLE, CTRL, CTRL_ACK, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
REQ-013 IDLE -> CTRL on START; repeated START in any state -> CTRL, bit counter cleared; STOP in any state -> IDLE, SDA released.
REQ-014 CTRL: after 8 bits, if bits[7:4] == DEV_ID -> CTRL_ACK, else WAIT_STOP with SDA released (NACK).
REQ-015 ACK: SDA pulled low from SCL falling edge after 8th bit to the next SCL falling edge.
REQ-016 Control byte bits[3:1] form pointer bits [10:8] (upper ADDR_W-8 bits, truncated/zero-extended if ADDR_W != 11); bit[0] = R/W.
REQ-017 CTRL_ACK: R/W=0 -> ADDR; R/W=1 -> RDATA, pointer upper bits loaded from control byte, lower bits retained.
REQ-018 ADDR: 8 bits load pointer[7:0] -> ADDR_ACK (always ACK) -> WDATA.
REQ-019 WDATA: on 8th sampled bit, byte written to mem[pointer], WR_PULSE asserted one CLK, pointer increments -> WDATA_ACK.
REQ-020 Pointer increment wraps modulo 2^ADDR_W (e.g. 11'h7FF -> 11'h000).
REQ-021 RDATA: mem[pointer] loaded at CTRL_ACK/RDATA_ACK exit; bit=0 pulls SDA low, bit=1 releases; after 8 bits pointer increments -> RDATA_ACK with SDA released.
REQ-022 RDATA_ACK: master SDA low on SCL rising = ACK -> next RDATA byte; high = NACK -> WAIT_STOP.
REQ-023 WAIT_STOP: SDA released; exits only on START or STOP.
REQ-024 Simultaneous STOP and 8th-bit commit cannot both occur (STOP needs SCL high without rising edge); partial bytes at STOP/START are discarded, no write.

Reset
REQ-025 RESET low: state IDLE, SDA high-Z, BUSY 0, WR_PULSE 0, pointer 0, bit counter 0, synchronizers 1; memory contents not reset.
REQ-026 Reset mid-transaction releases SDA immediately (asynchronously); no partial write.
REQ-027 After RESET release, block waits for a fresh START.

Configuration
REQ-028 Macro EEPROM_SEQ_ACCESS_EN defined: multi-byte writes (WDATA_ACK -> WDATA) and sequential reads (ACK -> RDATA) with auto-increment.
REQ-029 Macro not defined: after first data byte, WDATA_ACK -> WAIT_STOP and further write bytes get NACK with no commit; after first read byte, RDATA_ACK -> WAIT_STOP regardless of master ACK; pointer still increments once.

Verification
REQ-030 START, ctrl 8'hA2, addr 8'h34, data 8'h5A, STOP -> three ACKs, WR_PULSE once, mem[11'h134]=8'h5A, BUSY low after STOP.
REQ-031 START, ctrl 8'hA2, addr 8'h34, repeated START, ctrl 8'hA3, master NACK, STOP -> SDA returns 8'h5A, pointer 11'h135.
REQ-032 START, ctrl 8'hB0 -> no ACK (SDA high on 9th clock), no write, WAIT_STOP until STOP.
REQ-033 With EEPROM_SEQ_ACCESS_EN: write 8'h11,8'h22 at 11'h7FF -> mem[11'h7FF]=8'h11, mem[11'h000]=8'h22, WR_PULSE twice; without macro: second byte NACKed, mem[11'h000] unchanged.
REQ-034 RESET low during 5th bit of a read byte with SDA driven low -> SDA high-Z within same CLK, BUSY 0; next transaction at 8'hA2 ACKed normally.
REQ-035 STOP after 4 bits of a write data byte -> no WR_PULSE, memory unchanged, state IDLE.
